// File: rtl/game_table_ctrl.sv
// game_table_ctrl
//
// Write-port controller for the 30x40 tile game table RAM. Two tile-update
// requesters share the single RAM write port through round-robin arbitration;
// each (row, col) request is converted to a linear address, and out-of-range
// coordinates are rejected without a write. A fill engine sweeps every cell
// with one tile code for level clear / init. The video read port is not
// touched here.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   fill_start, fill_val     start a full-table fill with tile code fill_val
//   fill_busy, fill_done     fill writes in progress / pulse after last write
//   reqN, rowN, colN, dataN  tile write request from requester N (N = 0, 1)
//   ackN, errN               pulse: write performed / coordinates rejected
//   ram_we, ram_waddr, ram_din  RAM write port
//
// Every output is registered; the combinational processes below compute the
// values the output registers take on the next rising edge.

module game_table_ctrl #(
    parameter int ROWS   = 30,
    parameter int COLS   = 40,
    parameter int ROW_W  = 5,
    parameter int COL_W  = 6,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_val,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              req0,
    input  logic [ROW_W-1:0]  row0,
    input  logic [COL_W-1:0]  col0,
    input  logic [DATA_W-1:0] data0,
    output logic              ack0,
    output logic              err0,
    input  logic              req1,
    input  logic [ROW_W-1:0]  row1,
    input  logic [COL_W-1:0]  col1,
    input  logic [DATA_W-1:0] data1,
    output logic              ack1,
    output logic              err1,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_din
);

    typedef enum logic [0:0] {IDLE, FILL} state_t;

    localparam logic [ROW_W-1:0]  ROW_LIM = ROW_W'(ROWS);
    localparam logic [COL_W-1:0]  COL_LIM = COL_W'(COLS);
    localparam logic [ADDR_W-1:0] COLS_A  = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] CELLS   = ADDR_W'(ROWS * COLS);

    state_t              state, state_nxt;
    logic                ptr, ptr_nxt;          // 0: requester 0 wins a tie
    logic [ADDR_W-1:0]   fill_cnt, fill_cnt_nxt;
    logic [DATA_W-1:0]   fill_val_q;

    logic                elig0, elig1, grant0, grant1;
    logic                in_range0, in_range1;
    logic [ADDR_W-1:0]   addr0, addr1;

    logic                we_nxt, busy_nxt, done_nxt;
    logic                ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;
    logic [ADDR_W-1:0]   waddr_nxt;
    logic [DATA_W-1:0]   din_nxt;

    // A requester answered this cycle is still holding req; masking it keeps
    // the same request from being served twice.
    assign elig0  = req0 & ~ack0 & ~err0;
    assign elig1  = req1 & ~ack1 & ~err1;
    assign grant0 = elig0 & (~elig1 | ~ptr);
    assign grant1 = elig1 & (~elig0 |  ptr);

    assign in_range0 = (row0 < ROW_LIM) && (col0 < COL_LIM);
    assign in_range1 = (row1 < ROW_LIM) && (col1 < COL_LIM);
    assign addr0     = ADDR_W'(row0) * COLS_A + ADDR_W'(col0);
    assign addr1     = ADDR_W'(row1) * COLS_A + ADDR_W'(col1);

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            fill_cnt  <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_din   <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            fill_busy <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            fill_cnt  <= fill_cnt_nxt;
            ram_we    <= we_nxt;
            ram_waddr <= waddr_nxt;
            ram_din   <= din_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            err0      <= err0_nxt;
            err1      <= err1_nxt;
            fill_busy <= busy_nxt;
            fill_done <= done_nxt;
        end
    end

    // Fill tile code is captured only when a fill is launched from IDLE.
    always_ff @(posedge clk) begin
        if (state == IDLE && fill_start) begin
            fill_val_q <= fill_val;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fill_start) state_nxt = FILL;
            FILL: if (fill_cnt == CELLS) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        we_nxt       = 1'b0;
        waddr_nxt    = '0;
        din_nxt      = '0;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        err0_nxt     = 1'b0;
        err1_nxt     = 1'b0;
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        ptr_nxt      = ptr;
        fill_cnt_nxt = fill_cnt;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    // Address 0 is written straight from the launch edge, so
                    // the counter continues from 1 inside FILL.
                    we_nxt       = 1'b1;
                    din_nxt      = fill_val;
                    busy_nxt     = 1'b1;
                    fill_cnt_nxt = ADDR_W'(1);
                end else if (grant0) begin
                    ptr_nxt = 1'b1;
                    if (in_range0) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = addr0;
                        din_nxt   = data0;
                        ack0_nxt  = 1'b1;
                    end else begin
                        err0_nxt = 1'b1;
                    end
                end else if (grant1) begin
                    ptr_nxt = 1'b0;
                    if (in_range1) begin
                        we_nxt    = 1'b1;
                        waddr_nxt = addr1;
                        din_nxt   = data1;
                        ack1_nxt  = 1'b1;
                    end else begin
                        err1_nxt = 1'b1;
                    end
                end
            end
            FILL: begin
                if (fill_cnt == CELLS) begin
                    // Last cell already issued: this edge produces fill_done
                    // and hands the port back to the requesters.
                    done_nxt     = 1'b1;
                    fill_cnt_nxt = '0;
                end else begin
                    we_nxt       = 1'b1;
                    waddr_nxt    = fill_cnt;
                    din_nxt      = fill_val_q;
                    busy_nxt     = 1'b1;
                    fill_cnt_nxt = fill_cnt + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_game_table_ctrl.sv
module tb_game_table_ctrl;

    localparam int ROW_W  = 5;
    localparam int COL_W  = 6;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 4;
    localparam int CELLS  = 1200;

    logic              clk = 1'b0;
    logic              rst;
    logic              fill_start;
    logic [DATA_W-1:0] fill_val;
    logic              fill_busy, fill_done;
    logic              req0, req1;
    logic [ROW_W-1:0]  row0, row1;
    logic [COL_W-1:0]  col0, col1;
    logic [DATA_W-1:0] data0, data1;
    logic              ack0, ack1, err0, err1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_din;

    game_table_ctrl dut (
        .clk(clk), .rst(rst),
        .fill_start(fill_start), .fill_val(fill_val),
        .fill_busy(fill_busy), .fill_done(fill_done),
        .req0(req0), .row0(row0), .col0(col0), .data0(data0),
        .ack0(ack0), .err0(err0),
        .req1(req1), .row1(row1), .col1(col1), .data1(data1),
        .ack1(ack1), .err1(err1),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              ack0, ack1, err0, err1, busy, done;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(logic we, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d,
                                logic a0, logic a1, logic e0, logic e1, logic b, logic dn);
        exp_t e;
        e.we = we; e.addr = a; e.din = d;
        e.ack0 = a0; e.ack1 = a1; e.err0 = e0; e.err1 = e1; e.busy = b; e.done = dn;
        return e;
    endfunction

    // Monitor: every cycle the DUT shows any activity, pop one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ram_we | ack0 | ack1 | err0 | err1 | fill_busy | fill_done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output we=%0b addr=%0d din=%0d ack=%0b%0b err=%0b%0b busy=%0b done=%0b, required no activity",
                         ram_we, ram_waddr, ram_din, ack0, ack1, err0, err1, fill_busy, fill_done);
            end else begin
                e = sb_q.pop_front();
                if ({ram_we, ack0, ack1, err0, err1, fill_busy, fill_done} !=
                        {e.we, e.ack0, e.ack1, e.err0, e.err1, e.busy, e.done} ||
                    (e.we && (ram_waddr != e.addr || ram_din != e.din))) begin
                    errors++;
                    $display("FAIL output_cycle got we=%0b addr=%0d din=%0d ack=%0b%0b err=%0b%0b busy=%0b done=%0b, required we=%0b addr=%0d din=%0d ack=%0b%0b err=%0b%0b busy=%0b done=%0b",
                             ram_we, ram_waddr, ram_din, ack0, ack1, err0, err1, fill_busy, fill_done,
                             e.we, e.addr, e.din, e.ack0, e.ack1, e.err0, e.err1, e.busy, e.done);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({ram_we, ram_waddr, ram_din, ack0, ack1, err0, err1, fill_busy, fill_done} != '0) begin
            errors++;
            $display("FAIL %s got we=%0b addr=%0d din=%0d ack=%0b%0b err=%0b%0b busy=%0b done=%0b, required all 0",
                     name, ram_we, ram_waddr, ram_din, ack0, ack1, err0, err1, fill_busy, fill_done);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("reset_state");
    endtask

    // Wait (bounded) for the scoreboard to empty, then confirm it is empty.
    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d, required 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic push_fill(input logic [DATA_W-1:0] v, input int n, input bit with_done);
        for (int i = 0; i < n; i++)
            sb_q.push_back(mk(1'b1, ADDR_W'(i), v, 0, 0, 0, 0, 1'b1, 1'b0));
        if (with_done)
            sb_q.push_back(mk(1'b0, '0, '0, 0, 0, 0, 0, 1'b0, 1'b1));
    endtask

    // One request pulse: req high for exactly one sampling edge.
    task automatic req_once(input int idx, input logic [ROW_W-1:0] r,
                            input logic [COL_W-1:0] c, input logic [DATA_W-1:0] d);
        if (idx == 0) begin req0 = 1'b1; row0 = r; col0 = c; data0 = d; end
        else          begin req1 = 1'b1; row1 = r; col1 = c; data1 = d; end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; fill_start = 1'b0; fill_val = '0;
        req0 = 1'b0; row0 = '0; col0 = '0; data0 = '0;
        req1 = 1'b0; row1 = '0; col1 = '0; data1 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("reset_state");

        // Single in-range request: 2*40+3 = 83
        sb_q.push_back(mk(1'b1, 11'd83, 4'd5, 1, 0, 0, 0, 0, 0));
        req_once(0, 5'd2, 6'd3, 4'd5);
        drain("single_req", 20);

        // Both held: alternate ack0 (addr 0) / ack1 (addr 29*40+39 = 1199)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(mk(1'b1, 11'd0,    4'd1, 1, 0, 0, 0, 0, 0));
            sb_q.push_back(mk(1'b1, 11'd1199, 4'd2, 0, 1, 0, 0, 0, 0));
        end
        req0 = 1'b1; row0 = 5'd0;  col0 = 6'd0;  data0 = 4'd1;
        req1 = 1'b1; row1 = 5'd29; col1 = 6'd39; data1 = 4'd2;
        repeat (6) @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        drain("round_robin", 20);

        // Out-of-range rows/cols, then an in-range request (1*40+2 = 42)
        do_reset();
        sb_q.push_back(mk(1'b0, '0, '0, 0, 0, 0, 1, 0, 0));
        req_once(1, 5'd30, 6'd0, 4'd0);
        sb_q.push_back(mk(1'b0, '0, '0, 0, 0, 0, 1, 0, 0));
        req_once(1, 5'd0, 6'd40, 4'd0);
        sb_q.push_back(mk(1'b1, 11'd42, 4'd9, 0, 1, 0, 0, 0, 0));
        req_once(1, 5'd1, 6'd2, 4'd9);
        drain("range_err", 20);

        // Full fill with 7; fill_val changed afterwards must not matter
        do_reset();
        push_fill(4'd7, CELLS, 1'b1);
        fill_val = 4'd7; fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0; fill_val = 4'd3;
        drain("fill", CELLS + 50);
        check_zero("after_fill");

        // fill_start with req0 in the same cycle; second fill_start mid-fill ignored
        do_reset();
        push_fill(4'd7, CELLS, 1'b1);
        sb_q.push_back(mk(1'b1, 11'd41, 4'd4, 1, 0, 0, 0, 0, 0));
        fill_val = 4'd7; fill_start = 1'b1;
        req0 = 1'b1; row0 = 5'd1; col0 = 6'd1; data0 = 4'd4;
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        fill_start = 1'b1; fill_val = 4'd2;
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (1100) @(posedge clk);
        #1;
        req0 = 1'b0;
        drain("fill_vs_req", 50);

        // Reset after the 500th fill write, then a clean restart
        do_reset();
        push_fill(4'd7, 500, 1'b0);
        fill_val = 4'd7; fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
        repeat (499) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("reset_mid_fill");
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL mid_fill_writes pending=%0d, required 0", sb_q.size());
        end
        sb_q.delete();
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        push_fill(4'd5, CELLS, 1'b1);
        fill_val = 4'd5; fill_start = 1'b1;
        @(posedge clk); #1;
        fill_start = 1'b0;
        drain("refill", CELLS + 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_table_ctrl.md
# game_table_ctrl

Write-port controller for the 30x40 tile game table RAM. It shares the single RAM write port between two tile-update requesters (e.g. player logic and enemy logic) using round-robin arbitration. It converts each (row, col) request to a linear address and rejects out-of-range coordinates. It also provides a fill engine that sweeps every cell with one value for level clear or init. The RAM read port (video side) is not touched by this block.

## Interface
- ROWS, 30, table rows
- COLS, 40, table columns
- ROW_W, 5, row coordinate width
- COL_W, 6, column coordinate width
- ADDR_W, 11, RAM address width (holds ROWS*COLS-1)
- DATA_W, 4, tile code width
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fill_start  in  1  request a full-table fill; sampled only in IDLE
- fill_val  in  DATA_W  fill tile code, captured with fill_start
- fill_busy  out  1  high while fill writes are being issued
- fill_done  out  1  one-cycle pulse after the last fill write
- req0, req1  in  1  write request, held until ack or err
- row0, row1  in  ROW_W  target row, stable while req high
- col0, col1  in  COL_W  target column, stable while req high
- data0, data1  in  DATA_W  tile code to write
- ack0, ack1  out  1  one-cycle pulse: write performed
- err0, err1  out  1  one-cycle pulse: coordinates out of range, no write
- ram_we  out  1  RAM write enable
- ram_waddr  out  ADDR_W  RAM write address
- ram_din  out  DATA_W  RAM write data

## Operation
- All outputs are registered. Reset values: every output 0, state IDLE, round-robin pointer favours requester 0, fill counter 0.
- States:
  - IDLE: serves requests.
  - IDLE -> FILL when fill_start=1. fill_start has priority over any request in the same cycle.
  - FILL: issues one write per cycle to addresses 0..ROWS*COLS-1 with the captured fill_val.
  - FILL -> IDLE after the write to ROWS*COLS-1 is issued.
- Arbitration in IDLE:
  - Eligible = reqN high and ackN/errN not high this cycle. The echo cycle is masked, so a held req is never double-served.
  - One eligible requester: it is granted.
  - Both eligible: the pointer picks. After each grant the pointer moves to the other requester.
- On a grant:
  - In range (row<ROWS and col<COLS): addr = row*COLS + col, truncated to ADDR_W. Next cycle ram_we=1, ram_waddr=addr, ram_din=dataN, ackN=1.
  - Out of range: next cycle errN=1, ram_we=0. The pointer still advances.
- Requests are not served during FILL. They stay pending and are arbitrated normally once the state returns to IDLE.
- fill_start while in FILL is ignored. fill_val is not re-sampled.
- Reset mid-fill aborts the sweep: outputs go to reset values and no fill_done pulse is produced.
- ram_waddr and ram_din are don't-care when ram_we=0, but they must not be X after reset (reset to 0).

## Timing
- Request latency: req sampled high at edge k → ackN/errN and ram_we at cycle k+1 (one cycle).
- A single requester holding req continuously gets one write every 2 cycles. This is the requester's own echo-mask limit.
- Two requesters both holding req get alternating writes on consecutive cycles, 1 write/cycle total.
- Requesters must deassert req, or present new coordinates, in the cycle after ack/err. A req still high at that point is treated as a new request.
- Fill: fill_start sampled at edge k.
  - Cycles k+1..k+ROWS*COLS: fill_busy=1, ram_we=1, ram_waddr = 0,1,...,ROWS*COLS-1.
  - Cycle k+ROWS*COLS+1: fill_busy=0 and fill_done=1.
  - First request grant is possible at edge k+ROWS*COLS+1, with its write at the following cycle.
- An ack cycle already scheduled when fill_start arrives completes normally. The fill writes start the following cycle.

## Test plan
- Reset, then req0 with row=2, col=3, data=5 → next cycle ram_we=1, ram_waddr=83, ram_din=5, ack0=1; all other outputs 0.
- req0 and req1 raised together and held: req0 (row 0, col 0, data 1), req1 (row 29, col 39, data 2) → ack0 writing addr 0, then ack1 writing addr 1199 on the next cycle, then alternating; never two acks in one cycle.
- req1 with row=30, col=0, then row=0, col=40 → err1 pulses with ram_we=0 each time; a following in-range req1 is still acked.
- fill_start with fill_val=7 → exactly 1200 consecutive writes, addr 0..1199, data 7; fill_done pulses exactly once, one cycle after addr 1199; fill_busy is high for exactly 1200 cycles.
- fill_start and req0 in the same cycle → fill runs first; ack0 arrives only after fill_done; a second fill_start mid-fill has no effect.
- rst asserted at fill write 500 → next cycle all outputs 0 and no fill_done; a new fill_start restarts at addr 0.
